univ_shift_reg: RTL and testbench

UNIV_SHIFT_REG -- requirements
Module: univ_shift_reg

---
 rtl/usr_pkg.sv | 19 +
 rtl/univ_shift_reg_if.sv | 32 +++
 rtl/burst_cnt.sv | 38 +++
 rtl/univ_shift_reg.sv | 114 +++++++++++
 tb/tb_univ_shift_reg.sv | 177 +++++++++++++++++
 5 files changed

// File: rtl/usr_pkg.sv
// Shared constants for the universal shift register: idle-mode opcodes and
// burst FSM state encodings.
package usr_pkg;

  typedef logic [2:0] mode_t;

  localparam mode_t MODE_HOLD = 3'b000;
  localparam mode_t MODE_LOAD = 3'b001;
  localparam mode_t MODE_SHL  = 3'b010;
  localparam mode_t MODE_SHR  = 3'b011;
  localparam mode_t MODE_ROL  = 3'b100;
  localparam mode_t MODE_ROR  = 3'b101;
  localparam mode_t MODE_CLR  = 3'b110;
  localparam mode_t MODE_RSVD = 3'b111;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

endpackage

// File: rtl/univ_shift_reg_if.sv
// Control/data bundle of the universal shift register; the register side
// uses the slave modport, the driver side the master modport.
interface univ_shift_reg_if #(
  parameter int W  = 8,
  parameter int LW = $clog2(W) + 1
);
  import usr_pkg::*;

  logic [W-1:0]  I;
  mode_t         Mode;
  logic          SinL;
  logic          SinR;
  logic          Start;
  logic          Dir;
  logic [LW-1:0] Len;
  logic [W-1:0]  Q;
  logic          SoutL;
  logic          SoutR;
  logic          Busy;
  logic          Done;

  modport master (
    output I, Mode, SinL, SinR, Start, Dir, Len,
    input  Q, SoutL, SoutR, Busy, Done
  );

  modport slave (
    input  I, Mode, SinL, SinR, Start, Dir, Len,
    output Q, SoutL, SoutR, Busy, Done
  );

endinterface

// File: rtl/burst_cnt.sv
// Burst down-counter: loads a shift count, decrements once per burst shift
// and flags when it has reached zero.
module burst_cnt #(
  parameter int LW = 4
) (
  input  logic          Clk,
  input  logic          Rst,
  input  logic          load,
  input  logic          dec,
  input  logic [LW-1:0] load_val,
  output logic [LW-1:0] cnt,
  output logic          zero
);

  logic [LW-1:0] cnt_q;
  logic [LW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - LW'(1);
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt  = cnt_q;
  assign zero = (cnt_q == '0);

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register with idle-mode operations and a counted burst
// shift engine (IDLE/SHIFT FSM, Busy while shifting, one-cycle Done pulse).
module univ_shift_reg
  import usr_pkg::*;
#(
  parameter int W  = 8,
  parameter int LW = $clog2(W) + 1
) (
  input  logic            Clk,
  input  logic            Rst,
  univ_shift_reg_if.slave bus
);

  logic [0:0]    state_q, state_d;
  logic [W-1:0]  q_q, q_d;
  logic          dir_q, dir_d;
  logic          done_q, done_d;

  logic          cnt_load;
  logic          cnt_dec;
  logic [LW-1:0] cnt_val;
  logic          cnt_zero;
  logic          cnt_last;

  logic [W-1:0]  shl_val;
  logic [W-1:0]  shr_val;

  burst_cnt #(.LW(LW)) u_burst_cnt (
    .Clk      (Clk),
    .Rst      (Rst),
    .load     (cnt_load),
    .dec      (cnt_dec),
    .load_val (bus.Len),
    .cnt      (cnt_val),
    .zero     (cnt_zero)
  );

  assign shl_val  = {q_q[W-2:0], bus.SinR};
  assign shr_val  = {bus.SinL, q_q[W-1:1]};
  assign cnt_last = (cnt_val == LW'(1));

  always_comb begin
    state_d  = state_q;
    q_d      = q_q;
    dir_d    = dir_q;
    done_d   = 1'b0;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.Start) begin
          // A zero-length burst completes immediately without entering SHIFT.
          cnt_load = 1'b1;
          dir_d    = bus.Dir;
          if (bus.Len == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = ST_SHIFT;
          end
        end else begin
          case (bus.Mode)
            MODE_HOLD: q_d = q_q;
            MODE_LOAD: q_d = bus.I;
            MODE_SHL:  q_d = shl_val;
            MODE_SHR:  q_d = shr_val;
            MODE_ROL:  q_d = {q_q[W-2:0], q_q[W-1]};
            MODE_ROR:  q_d = {q_q[0], q_q[W-1:1]};
            MODE_CLR:  q_d = '0;
            MODE_RSVD: q_d = q_q;
            default:   q_d = q_q;
          endcase
        end
      end

      ST_SHIFT: begin
        if (!cnt_zero) begin
          q_d     = dir_q ? shr_val : shl_val;
          cnt_dec = 1'b1;
        end
        // Leave on the final shift so Done lands in the cycle after it.
        if (cnt_zero || cnt_last) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= ST_IDLE;
      q_q     <= '0;
      dir_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      dir_q   <= dir_d;
      done_q  <= done_d;
    end
  end

  assign bus.Q     = q_q;
  assign bus.SoutL = q_q[W-1];
  assign bus.SoutR = q_q[0];
  assign bus.Busy  = (state_q == ST_SHIFT);
  assign bus.Done  = done_q;

endmodule

// File: tb/tb_univ_shift_reg.sv
// Scoreboard bench for univ_shift_reg: directed scenarios then random
// stimulus, predicted by a behavioural model and checked by a monitor.
module tb_univ_shift_reg;

  localparam int W  = 8;
  localparam int LW = 4;

  typedef struct packed {
    logic [W-1:0] q;
    logic         soutl;
    logic         soutr;
    logic         busy;
    logic         done;
  } exp_t;

  logic Clk;
  logic Rst;

  univ_shift_reg_if #(.W(W), .LW(LW)) bus ();

  univ_shift_reg #(.W(W), .LW(LW)) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  exp_t exp_q[$];
  int   vec_cnt  = 0;
  int   miss_cnt = 0;

  // Behavioural model: register value as an integer plus remaining shifts.
  int m_q    = 0;
  int m_left = 0;
  bit m_dir  = 1'b0;
  bit m_done = 1'b0;

  function automatic void model_edge(input bit rst, input int i, input int mode,
                                     input bit sinl, input bit sinr, input bit start,
                                     input bit dir, input int len);
    if (rst) begin
      m_q    = 0;
      m_left = 0;
      m_done = 1'b0;
    end else if (m_left > 0) begin
      if (m_dir) m_q = (m_q >> 1) | (int'(sinl) << 7);
      else       m_q = ((m_q << 1) | int'(sinr)) & 255;
      m_left = m_left - 1;
      m_done = (m_left == 0);
    end else begin
      m_done = 1'b0;
      if (start) begin
        m_dir = dir;
        if (len == 0) m_done = 1'b1;
        else          m_left = len;
      end else begin
        case (mode)
          1: m_q = i & 255;
          2: m_q = ((m_q << 1) | int'(sinr)) & 255;
          3: m_q = (m_q >> 1) | (int'(sinl) << 7);
          4: m_q = ((m_q << 1) | (m_q >> 7)) & 255;
          5: m_q = (m_q >> 1) | ((m_q & 1) << 7);
          6: m_q = 0;
          default: m_q = m_q;
        endcase
      end
    end
  endfunction

  task automatic step(input bit rst, input logic [W-1:0] i, input logic [2:0] mode,
                      input bit sinl, input bit sinr, input bit start,
                      input bit dir, input logic [LW-1:0] len);
    exp_t e;
    @(negedge Clk);
    Rst       = rst;
    bus.I     = i;
    bus.Mode  = mode;
    bus.SinL  = sinl;
    bus.SinR  = sinr;
    bus.Start = start;
    bus.Dir   = dir;
    bus.Len   = len;
    model_edge(rst, int'(i), int'(mode), sinl, sinr, start, dir, int'(len));
    e.q     = m_q[W-1:0];
    e.soutl = m_q[W-1];
    e.soutr = m_q[0];
    e.busy  = (m_left > 0);
    e.done  = m_done;
    exp_q.push_back(e);
  endtask

  // Monitor: the DUT presents a new state after every edge.
  always @(posedge Clk) begin
    #1;
    if (exp_q.size() > 0) begin
      exp_t e;
      exp_t a;
      e = exp_q.pop_front();
      a = {bus.Q, bus.SoutL, bus.SoutR, bus.Busy, bus.Done};
      vec_cnt++;
      if (a !== e) begin
        miss_cnt++;
        $display("FAIL vec %0d: got Q=%h SoutL=%b SoutR=%b Busy=%b Done=%b, expected Q=%h SoutL=%b SoutR=%b Busy=%b Done=%b",
                 vec_cnt, a.q, a.soutl, a.soutr, a.busy, a.done,
                 e.q, e.soutl, e.soutr, e.busy, e.done);
      end else begin
        $display("vec %0d: Q=%h Busy=%b Done=%b ok", vec_cnt, a.q, a.busy, a.done);
      end
    end
  end

  initial begin
    Rst = 1'b1;
    bus.I = '0; bus.Mode = '0; bus.SinL = 1'b0; bus.SinR = 1'b0;
    bus.Start = 1'b0; bus.Dir = 1'b0; bus.Len = '0;

    // Reset, load and hold
    step(1, 8'h00, 3'b000, 0, 0, 0, 0, 4'd0);
    step(0, 8'hA5, 3'b001, 0, 0, 0, 0, 4'd0);
    repeat (3) step(0, 8'h00, 3'b000, 0, 0, 0, 0, 4'd0);
    // Left shift with SinR=1, then rotate right
    step(0, 8'h00, 3'b010, 0, 1, 0, 0, 4'd0);
    step(0, 8'hA5, 3'b001, 0, 0, 0, 0, 4'd0);
    step(0, 8'h00, 3'b101, 0, 0, 0, 0, 4'd0);
    // Right burst of 3 from 0xF0 while Mode=load is attempted
    step(0, 8'hF0, 3'b001, 0, 0, 0, 0, 4'd0);
    step(0, 8'h00, 3'b000, 0, 0, 1, 1, 4'd3);
    repeat (3) step(0, 8'hFF, 3'b001, 0, 0, 1, 0, 4'd7);
    step(0, 8'h00, 3'b000, 0, 0, 0, 0, 4'd0);
    // Zero-length burst
    step(0, 8'h3C, 3'b001, 0, 0, 0, 0, 4'd0);
    step(0, 8'h00, 3'b000, 0, 0, 1, 0, 4'd0);
    step(0, 8'h00, 3'b000, 0, 0, 0, 0, 4'd0);
    // Burst longer than W, with a new Start in the Done cycle
    step(0, 8'h81, 3'b001, 0, 0, 0, 0, 4'd0);
    step(0, 8'h00, 3'b000, 1, 0, 1, 1, 4'd11);
    repeat (11) step(0, 8'h00, 3'b000, 1, 0, 0, 0, 4'd0);
    step(0, 8'h00, 3'b000, 0, 1, 1, 0, 4'd2);
    repeat (3) step(0, 8'h00, 3'b000, 0, 1, 0, 0, 4'd0);
    // Reset after the 2nd shift of a Len=5 burst
    step(0, 8'hF0, 3'b001, 0, 0, 0, 0, 4'd0);
    step(0, 8'h00, 3'b000, 0, 1, 1, 0, 4'd5);
    repeat (2) step(0, 8'h00, 3'b000, 0, 1, 0, 0, 4'd0);
    step(1, 8'h00, 3'b000, 0, 1, 0, 0, 4'd0);
    repeat (8) step(0, 8'h00, 3'b000, 0, 0, 0, 0, 4'd0);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      step(($urandom_range(0, 59) == 0),
           W'($urandom),
           3'($urandom_range(0, 7)),
           1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)),
           ($urandom_range(0, 4) == 0),
           1'($urandom_range(0, 1)),
           LW'($urandom_range(0, 15)));
    end

    repeat (3) @(negedge Clk);
    vec_cnt++;
    if (exp_q.size() != 0) begin
      miss_cnt++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

endmodule
